// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from a FWFT TX FIFO and shifts out 8N1/8N2 frames.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_engine #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] uart_clock_divide,
   input  logic [7:0]  fifo_data,
   input  logic        fifo_data_present,
   output logic        fifo_read,
   output logic        serial_out,
   output logic        tx_busy,
   output logic        tx_done
);

   localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      , ST_PARITY = 3'd4
`endif
   } state_t;

   function automatic logic frame_parity(input logic [DATA_BITS-1:0] data);
      if (PARITY_ODD != 0) begin
         return ~(^data);
      end else begin
         return ^data;
      end
   endfunction

   state_t               state_r;
   state_t               state_nxt_s;
   logic [15:0]          baud_cnt_r;
   logic [15:0]          baud_nxt_s;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] shift_nxt_s;
   logic [2:0]           bit_cnt_r;
   logic [2:0]           bit_nxt_s;
   logic                 fifo_read_r;
   logic                 read_nxt_s;
   logic                 serial_out_r;
   logic                 serial_nxt_s;
   logic                 tx_busy_r;
   logic                 busy_nxt_s;
   logic                 tx_done_r;
   logic                 done_nxt_s;
   logic                 baud_tick_s;
`ifdef UART_TX_PARITY_EN
   logic                 parity_r;
   logic                 parity_nxt_s;
`endif

   // Divide is compared live; >= lets a shrinking divide end the bit at once instead of wrapping.
   assign baud_tick_s = (baud_cnt_r >= uart_clock_divide);

   // Next-state and next-output decode; every output is registered from these values.
   always_comb begin
      state_nxt_s  = state_r;
      baud_nxt_s   = 16'd0;
      shift_nxt_s  = shift_r;
      bit_nxt_s    = bit_cnt_r;
      read_nxt_s   = 1'b0;
      serial_nxt_s = 1'b1;
      busy_nxt_s   = tx_busy_r;
      done_nxt_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_nxt_s = parity_r;
`endif
      if (state_r != ST_IDLE) begin
         baud_nxt_s = baud_tick_s ? 16'd0 : (baud_cnt_r + 16'd1);
      end else begin
         baud_nxt_s = 16'd0;
      end

      case (state_r)
         ST_IDLE: begin
            if (enable && fifo_data_present) begin
               state_nxt_s  = ST_START;
               read_nxt_s   = 1'b1;
               busy_nxt_s   = 1'b1;
               shift_nxt_s  = fifo_data[DATA_BITS-1:0];
               bit_nxt_s    = 3'd0;
               serial_nxt_s = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_nxt_s = frame_parity(fifo_data[DATA_BITS-1:0]);
`endif
            end else begin
               serial_nxt_s = 1'b1;
            end
         end
         ST_START: begin
            if (baud_tick_s) begin
               state_nxt_s  = ST_DATA;
               serial_nxt_s = shift_r[0];
            end else begin
               serial_nxt_s = 1'b0;
            end
         end
         ST_DATA: begin
            if (!baud_tick_s) begin
               serial_nxt_s = shift_r[0];
            end else if (bit_cnt_r == BIT_LAST) begin
               bit_nxt_s = 3'd0;
`ifdef UART_TX_PARITY_EN
               state_nxt_s  = ST_PARITY;
               serial_nxt_s = parity_r;
`else
               state_nxt_s  = ST_STOP;
               serial_nxt_s = 1'b1;
`endif
            end else begin
               bit_nxt_s    = bit_cnt_r + 3'd1;
               shift_nxt_s  = {1'b0, shift_r[DATA_BITS-1:1]};
               serial_nxt_s = shift_r[1];
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_tick_s) begin
               state_nxt_s  = ST_STOP;
               serial_nxt_s = 1'b1;
            end else begin
               serial_nxt_s = parity_r;
            end
         end
`endif
         ST_STOP: begin
            serial_nxt_s = 1'b1;
            if (baud_tick_s && (bit_cnt_r == STOP_LAST)) begin
               state_nxt_s = ST_IDLE;
               bit_nxt_s   = 3'd0;
               busy_nxt_s  = 1'b0;
               done_nxt_s  = 1'b1;
            end else if (baud_tick_s) begin
               bit_nxt_s = bit_cnt_r + 3'd1;
            end else begin
               bit_nxt_s = bit_cnt_r;
            end
         end
         default: begin
            state_nxt_s  = ST_IDLE;
            busy_nxt_s   = 1'b0;
            serial_nxt_s = 1'b1;
         end
      endcase
   end

   // State and output registers; reset drops an in-flight byte and parks the line high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         baud_cnt_r   <= 16'd0;
         shift_r      <= '0;
         bit_cnt_r    <= 3'd0;
         fifo_read_r  <= 1'b0;
         serial_out_r <= 1'b1;
         tx_busy_r    <= 1'b0;
         tx_done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_r     <= 1'b0;
`endif
      end else begin
         state_r      <= state_nxt_s;
         baud_cnt_r   <= baud_nxt_s;
         shift_r      <= shift_nxt_s;
         bit_cnt_r    <= bit_nxt_s;
         fifo_read_r  <= read_nxt_s;
         serial_out_r <= serial_nxt_s;
         tx_busy_r    <= busy_nxt_s;
         tx_done_r    <= done_nxt_s;
`ifdef UART_TX_PARITY_EN
         parity_r     <= parity_nxt_s;
`endif
      end
   end

   assign fifo_read  = fifo_read_r;
   assign serial_out = serial_out_r;
   assign tx_busy    = tx_busy_r;
   assign tx_done    = tx_done_r;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine with a small FWFT FIFO model.
// Honours `define UART_TX_PARITY_EN (even parity, 11-bit frames).
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic        clk;
   logic        reset;
   logic        enable;
   logic [15:0] uart_clock_divide;
   logic [7:0]  fifo_data;
   logic        fifo_data_present;
   logic        fifo_read;
   logic        serial_out;
   logic        tx_busy;
   logic        tx_done;

   logic [7:0]  fifo_mem [0:15];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          read_cnt = 0;
   int          empty_reads = 0;
   int          n_checks = 0;
   int          n_fails = 0;

   uart_tx_engine dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .uart_clock_divide (uart_clock_divide),
      .fifo_data         (fifo_data),
      .fifo_data_present (fifo_data_present),
      .fifo_read         (fifo_read),
      .serial_out        (serial_out),
      .tx_busy           (tx_busy),
      .tx_done           (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_data         = fifo_mem[rd_ptr[3:0]];
   assign fifo_data_present = (wr_ptr != rd_ptr);

   // FIFO pops on the edge that ends the fifo_read cycle
   always @(posedge clk) begin
      if (fifo_read) begin
         read_cnt <= read_cnt + 1;
         if (fifo_data_present) rd_ptr <= rd_ptr + 1;
         else empty_reads <= empty_reads + 1;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_mem[wr_ptr[3:0]] = b;
      wr_ptr++;
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input int j);
      if (j == 0) return 1'b0;
      else if (j <= 8) return d[j-1];
`ifdef UART_TX_PARITY_EN
      else if (j == 9) return ^d;
`endif
      else return 1'b1;
   endfunction

   task automatic wait_pop(input string tag, input int limit);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fifo_read && n < limit);
      chk_eq({tag, "_pop"}, 32'(fifo_read), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      while (!tx_done && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk_eq({tag, "_done"}, 32'(tx_done), 32'd1);
   endtask

   // Call at the negedge showing the first clock of the start bit
   task automatic check_frame(input string tag, input logic [7:0] d, input int div);
      chk_eq({tag, "_busy"}, 32'(tx_busy), 32'd1);
      for (int j = 0; j < NBITS; j++) begin
         for (int c = 0; c <= div; c++) begin
            if (j != 0 || c != 0) @(negedge clk);
            chk_eq($sformatf("%s_bit%0d_c%0d", tag, j, c), 32'(serial_out), 32'(exp_bit(d, j)));
         end
      end
      @(negedge clk);
      chk_eq({tag, "_done"}, 32'(tx_done), 32'd1);
      chk_eq({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
      chk_eq({tag, "_idle_line"}, 32'(serial_out), 32'd1);
   endtask

   initial begin
      int bad;
      int len;
      logic exp_line [0:9];
      reset = 1'b0;
      enable = 1'b0;
      uart_clock_divide = 16'd3;

      // reset values
      repeat (2) @(negedge clk);
      chk_eq("rst_read", 32'(fifo_read), 32'd0);
      chk_eq("rst_line", 32'(serial_out), 32'd1);
      chk_eq("rst_busy", 32'(tx_busy), 32'd0);
      chk_eq("rst_done", 32'(tx_done), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // 0x55 at divide 3: 40-clock frame, one pop
      push(8'h55);
      enable = 1'b1;
      wait_pop("f55", 2);
      check_frame("f55", 8'h55, 3);
      @(negedge clk);
      chk_eq("f55_done_pulse", 32'(tx_done), 32'd0);
      chk_eq("f55_line_high", 32'(serial_out), 32'd1);
      chk_eq("f55_reads", 32'(read_cnt), 32'd1);

      // back-to-back 0xA3, 0x0F at divide 0
      uart_clock_divide = 16'd0;
      push(8'hA3);
      push(8'h0F);
      wait_pop("fa3", 2);
      check_frame("fa3", 8'hA3, 0);
      wait_pop("b2b", 1);
      check_frame("f0f", 8'h0F, 0);
      chk_eq("b2b_reads", 32'(read_cnt), 32'd3);

      // disabled with data present: no pop, line high
      enable = 1'b0;
      push(8'h3C);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (fifo_read || !serial_out) bad++;
      end
      chk_eq("en0_quiet", 32'(bad), 32'd0);
      enable = 1'b1;
      wait_pop("en1", 1);
      check_frame("f3c", 8'h3C, 0);

      // reset in the middle of data bit 0 of 0x96 at divide 7
      uart_clock_divide = 16'd7;
      push(8'h96);
      wait_pop("f96", 2);
      repeat (10) @(negedge clk);
      chk_eq("pre_rst_line", 32'(serial_out), 32'd0);
      chk_eq("pre_rst_busy", 32'(tx_busy), 32'd1);
      reset = 1'b0;
      #1;
      chk_eq("mid_rst_line", 32'(serial_out), 32'd1);
      chk_eq("mid_rst_busy", 32'(tx_busy), 32'd0);
      chk_eq("mid_rst_read", 32'(fifo_read), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_eq("post_rst_line", 32'(serial_out), 32'd1);
      push(8'h5A);
      wait_pop("f5a", 2);
      check_frame("f5a", 8'h5A, 7);

      // parity bytes 0x07 (even parity 1) and 0x03 (0), divide 1
      uart_clock_divide = 16'd1;
      push(8'h07);
      push(8'h03);
      wait_pop("f07", 2);
      check_frame("f07", 8'h07, 1);
      wait_pop("f03", 1);
      check_frame("f03", 8'h03, 1);
      chk_eq("par_reads", 32'(read_cnt), 32'd8);

      // divide 9 -> 2 at count 5 during start bit, then enable drop mid-frame
      uart_clock_divide = 16'd9;
      push(8'h55);
      push(8'h81);
      wait_pop("fdiv", 2);
      repeat (5) @(negedge clk);
      uart_clock_divide = 16'd2;
      enable = 1'b0;
      exp_line = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int k = 0; k < 10; k++) begin
         if (k != 0) @(negedge clk);
         chk_eq($sformatf("div_chg_clk%0d", k + 5), 32'(serial_out), 32'(exp_line[k]));
      end
      wait_done("div_chg", 60);
      repeat (20) @(negedge clk);
      chk_eq("en_drop_reads", 32'(read_cnt), 32'd9);
      chk_eq("en_drop_line", 32'(serial_out), 32'd1);

      // divide 0xFFFF: start bit of 0x81 lasts 65536 clocks
      uart_clock_divide = 16'hFFFF;
      enable = 1'b1;
      wait_pop("fmax", 2);
      len = 0;
      while (serial_out == 1'b0 && len < 70000) begin
         len++;
         @(negedge clk);
      end
      chk_eq("max_div_start_len", 32'(len), 32'd65536);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_eq("final_reads", 32'(read_cnt), 32'd10);
      chk_eq("empty_reads", 32'(empty_reads), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
